slowmpy_arbiter: RTL and testbench
==================================

# slowmpy_arbiter

Round-robin controller sharing one shift-add sequential multiplier among 2^LGNR requesters. It accepts one operand pair at a time, issues it to the multiplier, waits for completion, and returns the product tagged with the requester index. It sits between several bus-side clients (e.g. CPU and DSP engines) and a single area-cheap multiplier instance.

## Interface
- IW, 32: operand width; product is 2*IW bits.
- LGNR, 2: log2 of requester count; NR = 2^LGNR.
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  NR  per-requester request valid.
- i_a  in  NR*IW  operand A, requester k in bits [k*IW +: IW].
- i_b  in  NR*IW  operand B, same packing.
- o_ready  out  NR  one-hot grant; handshake when i_valid[k] && o_ready[k].
- o_busy  out  1  controller not in IDLE.
- o_rvalid  out  1  one-cycle result strobe.
- o_rid  out  LGNR  requester index of the result.
- o_result  out  2*IW  product.
- o_mpy_stb  out  1  start strobe to multiplier.
- o_mpy_a, o_mpy_b  out  IW  multiplier operands.
- i_mpy_busy  in  1  multiplier busy.
- i_mpy_result  in  2*IW  multiplier product, valid once i_mpy_busy falls.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if i_mpy_busy==0 and any i_valid, o_ready = combinational one-hot grant of first valid requester at or after (rr_ptr+1) mod NR; else o_ready=0. On handshake latch operands and index, rr_ptr <= granted index, -> ISSUE.
- ISSUE: o_mpy_stb=1 with registered o_mpy_a/o_mpy_b; -> WAIT unconditionally.
- WAIT: stay while i_mpy_busy; when low, register i_mpy_result into o_result (post-processed per Configuration), -> DONE.
- DONE: o_rvalid=1, o_rid = latched index; -> IDLE. o_ready=0 in all non-IDLE states.
- o_result and o_rid hold until the next DONE.
- Requester k must hold i_valid, i_a, i_b stable until handshake; requests are never dropped.
- No result back-pressure: client must sample on o_rvalid.

## Timing
- Reset values: state IDLE, rr_ptr=NR-1 (requester 0 highest priority first), o_mpy_stb=0, o_mpy_a=o_mpy_b=0, o_rvalid=0, o_rid=0, o_result=0, o_busy=0.
- Handshake at cycle T; o_mpy_stb at T+1; multiplier busy T+2..T+1+B; result latched at T+2+B; o_rvalid at T+3+B. IW=32 multiplier has B=32: o_rvalid at T+35.
- Next handshake earliest T+4+B; throughput one op per B+4 cycles.
- Reset mid-operation: return to IDLE next edge, in-flight result discarded, o_rvalid never asserted for it; IDLE withholds grants until a still-running multiplier drops i_mpy_busy.
- All requesters continuously valid: grants rotate 0,1,...,NR-1,0.
- Single requester: served every B+4 cycles with no idle gap beyond that.

## Configuration
- SLOWMPY_ARB_SIGNED_EN defined: operands are two's complement. ISSUE sends |a| and |b| (IW-bit unsigned; -2^(IW-1) maps to 2^(IW-1)); sign = a[IW-1]^b[IW-1] latched at handshake; WAIT negates product when sign set. Latency unchanged.
- Undefined: operands and product unsigned; raw i_mpy_result passed through; no sign logic synthesized.

## Test plan
- Reset then single request: requester 2 valid, a=3, b=5 -> grant at T, o_mpy_stb at T+1, o_rvalid at T+35, o_rid=2, o_result=15.
- All four valid continuously -> results in order rid 0,1,2,3,0, each o_rvalid 36 cycles apart.
- Unsigned max: a=b=32'hFFFFFFFF -> o_result=64'hFFFFFFFE00000001.
- i_reset pulsed during WAIT while multiplier busy -> no o_rvalid for that op; no o_ready until i_mpy_busy low; next request a=7, b=6 returns 42.
- With SLOWMPY_ARB_SIGNED_EN: a=-3, b=5 -> o_result=-15 (64'hFFFFFFFFFFFFFFF1); a=b=32'h80000000 -> 64'h4000000000000000.
- i_valid withdrawn before grant (i_mpy_busy high) -> no handshake, no o_mpy_stb, o_busy stays 0.

Source files
------------

// File: rtl/slowmpy_arbiter.sv
// -----------------------------------------------------------------------------
// slowmpy_arbiter
//
// Round-robin front end that shares one slow shift-add multiplier among
// NR = 2^LGNR requesters. One operand pair is accepted at a time. It is issued
// to the multiplier with a one-cycle start strobe. The controller waits for the
// multiplier to drop busy, then returns the product tagged with the index of
// the requester that supplied it.
//
// Build option:
//   SLOWMPY_ARB_SIGNED_EN - operands and product are two's complement.
//                           Magnitudes go to the unsigned multiplier and the
//                           product is negated on return when the signs differ.
//                           When undefined, everything is unsigned.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_valid[NR]          per-requester request valid
//   i_a, i_b [NR*IW]     packed operands, requester k in [k*IW +: IW]
//   o_ready[NR]          one-hot grant, handshake on i_valid[k] && o_ready[k]
//   o_busy               controller is not idle
//   o_rvalid             one-cycle result strobe
//   o_rid [LGNR]         requester index belonging to o_result
//   o_result [2*IW]      product, held until the next result
//   o_mpy_stb            start strobe to the multiplier
//   o_mpy_a, o_mpy_b     multiplier operands
//   i_mpy_busy           multiplier busy
//   i_mpy_result [2*IW]  multiplier product, valid once i_mpy_busy falls
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | grant the next requester in rotation once the multiplier is free
// ISSUE | pulse o_mpy_stb with the latched operands
// WAIT  | hold until the multiplier drops busy, then capture the product
// DONE  | present o_rvalid for one cycle

module slowmpy_arbiter #(
  parameter int IW   = 32,
  parameter int LGNR = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [(1<<LGNR)-1:0]        i_valid,
  input  logic [(1<<LGNR)*IW-1:0]     i_a,
  input  logic [(1<<LGNR)*IW-1:0]     i_b,
  output logic [(1<<LGNR)-1:0]        o_ready,
  output logic                        o_busy,
  output logic                        o_rvalid,
  output logic [LGNR-1:0]             o_rid,
  output logic [2*IW-1:0]             o_result,
  output logic                        o_mpy_stb,
  output logic [IW-1:0]               o_mpy_a,
  output logic [IW-1:0]               o_mpy_b,
  input  logic                        i_mpy_busy,
  input  logic [2*IW-1:0]             i_mpy_result
);

  localparam int NR = 1 << LGNR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LGNR-1:0] rr_ptr;
  logic [LGNR-1:0] req_id;
  logic [NR-1:0]   grant;
  logic [LGNR-1:0] grant_idx;
  logic [LGNR-1:0] cand;
  logic            found;
  logic            handshake;
  logic            capture;

  logic [IW-1:0]   a_arr [NR];
  logic [IW-1:0]   b_arr [NR];
  logic [IW-1:0]   a_sel;
  logic [IW-1:0]   b_sel;
  logic [IW-1:0]   a_mag;
  logic [IW-1:0]   b_mag;
  logic [2*IW-1:0] result_post;

  // Unpack the operand buses so the granted pair can be picked by index.
  for (genvar k = 0; k < NR; k++) begin : g_unpack
    assign a_arr[k] = i_a[k*IW +: IW];
    assign b_arr[k] = i_b[k*IW +: IW];
  end

  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];

  // First valid requester at or after rr_ptr+1, wrapping modulo NR.
  // rr_ptr resets to NR-1, so requester 0 is searched first after reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NR; i++) begin
      cand = rr_ptr + LGNR'(i + 1);
      if (!found && i_valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

`ifdef SLOWMPY_ARB_SIGNED_EN
  logic sign_q;

  // Unary minus in IW bits maps -2^(IW-1) onto 2^(IW-1), which is exactly the
  // unsigned magnitude the multiplier needs.
  assign a_mag       = a_sel[IW-1] ? -a_sel : a_sel;
  assign b_mag       = b_sel[IW-1] ? -b_sel : b_sel;
  assign result_post = sign_q ? -i_mpy_result : i_mpy_result;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sign_q <= 1'b0;
    end else if (handshake) begin
      sign_q <= a_sel[IW-1] ^ b_sel[IW-1];
    end
  end
`else
  assign a_mag       = a_sel;
  assign b_mag       = b_sel;
  assign result_post = i_mpy_result;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    o_ready   = '0;
    o_mpy_stb = 1'b0;
    o_rvalid  = 1'b0;
    o_busy    = (state != IDLE);
    handshake = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // Grants are withheld while the multiplier still runs, which covers
        // an operation abandoned by a reset.
        if (!i_mpy_busy) begin
          o_ready = grant;
          if (found) begin
            handshake = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        o_mpy_stb = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!i_mpy_busy) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_rvalid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr   <= '1;
      req_id   <= '0;
      o_mpy_a  <= '0;
      o_mpy_b  <= '0;
      o_rid    <= '0;
      o_result <= '0;
    end else begin
      if (handshake) begin
        rr_ptr  <= grant_idx;
        req_id  <= grant_idx;
        o_mpy_a <= a_mag;
        o_mpy_b <= b_mag;
      end
      // o_rid moves together with o_result so both hold until the next result.
      if (capture) begin
        o_result <= result_post;
        o_rid    <= req_id;
      end
    end
  end

  grant_onehot: assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(o_ready));

endmodule

// File: tb/tb_slowmpy_arbiter.sv
module tb_slowmpy_arbiter;

  localparam int IW   = 32;
  localparam int LGNR = 2;
  localparam int NR   = 4;
  localparam int B    = 32;

  logic                clk = 1'b0;
  logic                i_reset;
  logic [NR-1:0]       i_valid;
  logic [NR*IW-1:0]    i_a;
  logic [NR*IW-1:0]    i_b;
  logic [NR-1:0]       o_ready;
  logic                o_busy;
  logic                o_rvalid;
  logic [LGNR-1:0]     o_rid;
  logic [2*IW-1:0]     o_result;
  logic                o_mpy_stb;
  logic [IW-1:0]       o_mpy_a;
  logic [IW-1:0]       o_mpy_b;
  logic                mpy_busy = 1'b0;
  logic [2*IW-1:0]     mpy_prod = '0;
  int                  mpy_cnt  = 0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slowmpy_arbiter #(.IW(IW), .LGNR(LGNR)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_ready      (o_ready),
    .o_busy       (o_busy),
    .o_rvalid     (o_rvalid),
    .o_rid        (o_rid),
    .o_result     (o_result),
    .o_mpy_stb    (o_mpy_stb),
    .o_mpy_a      (o_mpy_a),
    .o_mpy_b      (o_mpy_b),
    .i_mpy_busy   (mpy_busy),
    .i_mpy_result (mpy_prod)
  );

  // Multiplier stand-in: busy for exactly B cycles starting the cycle after
  // the strobe, product held afterwards. Not tied to the arbiter reset.
  always @(posedge clk) begin
    if (o_mpy_stb) begin
      mpy_busy <= 1'b1;
      mpy_cnt  <= B - 1;
      mpy_prod <= {{IW{1'b0}}, o_mpy_a} * {{IW{1'b0}}, o_mpy_b};
    end else if (mpy_busy) begin
      if (mpy_cnt == 0) mpy_busy <= 1'b0;
      else              mpy_cnt  <= mpy_cnt - 1;
    end
  end

  typedef struct {
    int              rid;
    logic [IW-1:0]   a;
    logic [IW-1:0]   b;
    logic [2*IW-1:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mag(input logic [IW-1:0] v);
`ifdef SLOWMPY_ARB_SIGNED_EN
    return v[IW-1] ? -v : v;
`else
    return v;
`endif
  endfunction

  // Called at a negedge. Presents one request, follows it to its result.
  task automatic run_one(input int rid, input logic [IW-1:0] a, input logic [IW-1:0] b,
                         input logic [2*IW-1:0] exp);
    int t0;
    int n;
    logic [NR-1:0] want;
    want = '0;
    want[rid] = 1'b1;
    i_valid = '0;
    i_valid[rid] = 1'b1;
    i_a[rid*IW +: IW] = a;
    i_b[rid*IW +: IW] = b;
    #1;
    n = 0;
    while (!o_ready[rid] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("grant_timeout", 64'(n), 64'(0));
      i_valid = '0;
      return;
    end
    check("grant_onehot", 64'(o_ready), 64'(want));
    t0 = cyc;
    @(negedge clk);
    i_valid = '0;
    check("issue_stb", 64'(o_mpy_stb), 64'(1));
    check("issue_a", 64'(o_mpy_a), 64'(mag(a)));
    check("issue_b", 64'(o_mpy_b), 64'(mag(b)));
    check("busy_active", 64'(o_busy), 64'(1));
    n = 0;
    while (!o_rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rvalid_latency", 64'(cyc - t0), 64'(B + 3));
    check("result_rid", 64'(o_rid), 64'(rid));
    check("result_value", o_result, exp);
    @(negedge clk);
    check("rvalid_pulse", 64'(o_rvalid), 64'(0));
    check("result_hold", o_result, exp);
    check("back_idle", 64'(o_busy), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SLOWMPY_ARB_SIGNED_EN
    vecs[0] = '{2, 32'd3,          32'd5,          64'd15};
    vecs[1] = '{2, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFFFFFFFFF1};
    vecs[2] = '{0, 32'h80000000,   32'h80000000,   64'h4000000000000000};
    vecs[3] = '{1, 32'hFFFFFFF9,   32'hFFFFFFFA,   64'd42};
    vecs[4] = '{3, 32'h7FFFFFFF,   32'd2,          64'h00000000FFFFFFFE};
`else
    vecs[0] = '{2, 32'd3,          32'd5,          64'd15};
    vecs[1] = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
    vecs[2] = '{1, 32'd0,          32'd1234,       64'd0};
    vecs[3] = '{3, 32'h00010000,   32'h00010000,   64'h0000000100000000};
    vecs[4] = '{2, 32'd7,          32'd6,          64'd42};
`endif

    i_reset = 1'b1;
    i_valid = '0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    check("rst_busy",   64'(o_busy),    64'(0));
    check("rst_rvalid", 64'(o_rvalid),  64'(0));
    check("rst_rid",    64'(o_rid),     64'(0));
    check("rst_result", o_result,       64'(0));
    check("rst_stb",    64'(o_mpy_stb), 64'(0));
    check("rst_mpy_a",  64'(o_mpy_a),   64'(0));
    check("rst_mpy_b",  64'(o_mpy_b),   64'(0));
    check("rst_ready",  64'(o_ready),   64'(0));
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // All requesters valid continuously: rotation 0,1,2,3,0 at B+4 spacing.
    do_reset();
    begin
      int got;
      int last;
      int n;
      int exp_rid;
      got  = 0;
      last = 0;
      n    = 0;
      for (int k = 0; k < NR; k++) begin
        i_a[k*IW +: IW] = IW'(k + 1);
        i_b[k*IW +: IW] = IW'(10);
      end
      i_valid = '1;
      while (got < 5 && n < 400) begin
        @(negedge clk);
        n++;
        if (o_rvalid) begin
          exp_rid = got % NR;
          check("rr_rid", 64'(o_rid), 64'(exp_rid));
          check("rr_result", o_result, 64'((exp_rid + 1) * 10));
          if (got > 0) check("rr_spacing", 64'(cyc - last), 64'(B + 4));
          last = cyc;
          got++;
          if (got == 5) i_valid = '0;
        end
      end
      if (got < 5) check("rr_count", 64'(got), 64'(5));
      i_valid = '0;
      repeat (2) @(negedge clk);
      check("rr_quiet", 64'(o_busy), 64'(0));
    end

    // Reset during WAIT; withdrawn request while the multiplier still runs.
    begin
      int n;
      int bad;
      int t_hs;
      i_valid = 4'b0010;
      i_a[1*IW +: IW] = IW'(9);
      i_b[1*IW +: IW] = IW'(9);
      #1;
      n = 0;
      while (!o_ready[1] && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("abort_grant", 64'(o_ready), 64'(4'b0010));
      @(negedge clk);
      i_valid = '0;
      repeat (10) @(negedge clk);
      check("abort_in_wait", 64'(o_busy), 64'(1));
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      bad  = 0;
      t_hs = 0;
      n    = 0;
      while (mpy_busy && n < 100) begin
        if (t_hs < 3) begin
          i_valid = 4'b0001;
          i_a[0*IW +: IW] = IW'(11);
          i_b[0*IW +: IW] = IW'(11);
        end else begin
          i_valid = 4'b1000;
          i_a[3*IW +: IW] = IW'(7);
          i_b[3*IW +: IW] = IW'(6);
        end
        #1;
        if (o_ready != '0 || o_mpy_stb || o_busy || o_rvalid) bad++;
        t_hs++;
        @(negedge clk);
        n++;
      end
      check("abort_window_seen", 64'(t_hs > 3), 64'(1));
      check("withhold_violations", 64'(bad), 64'(0));
      run_one(3, IW'(7), IW'(6), 64'd42);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
